// File: rtl/clk_pattern_detector_pkg.sv
// clk_pattern_detector_pkg: lane checker states and clock-repair pattern constants shared with the generator
package clk_pattern_detector_pkg;

    typedef enum logic [1:0] {HUNT, BURST, GAP} lane_state_e;

    localparam int HIGH_CYCLES_DEF    = 32;
    localparam int LOW_CYCLES_DEF     = 16;
    localparam int LOW_SLACK_DEF      = 2;
    localparam int PASS_THRESHOLD_DEF = 16;
    localparam int CNT_W_DEF          = 8;

endpackage

// File: rtl/clk_pattern_detector_lane.sv
// clk_lane_checker: validates one lane's burst/gap pattern and flags a run of consecutive good iterations
module clk_lane_checker
    import clk_pattern_detector_pkg::*;
#(
    parameter int HIGH_CYCLES    = HIGH_CYCLES_DEF,
    parameter int LOW_CYCLES     = LOW_CYCLES_DEF,
    parameter int LOW_SLACK      = LOW_SLACK_DEF,
    parameter int PASS_THRESHOLD = PASS_THRESHOLD_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic i_clk1,
    input  logic i_rst_n,
    input  logic sample,
    input  logic start,
    input  logic active,
    input  logic stop,
    output logic pass
);

    localparam logic [5:0] HIGH6 = 6'(HIGH_CYCLES);
    localparam logic [5:0] LOW6  = 6'(LOW_CYCLES);
    localparam logic [5:0] MAX6  = 6'(LOW_CYCLES + LOW_SLACK);

    lane_state_e      st, st_n, cs;
    logic [5:0]       pos, pos_n, cp;
    logic             prev, prev_n, pass_n;
    logic [CNT_W-1:0] cons, cons_n, cc, cons_inc;

    always_ff @(posedge i_clk1 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st   <= HUNT;
            pos  <= '0;
            prev <= 1'b0;
            cons <= '0;
            pass <= 1'b0;
        end else begin
            st   <= st_n;
            pos  <= pos_n;
            prev <= prev_n;
            cons <= cons_n;
            pass <= pass_n;
        end
    end

    // A window start resets the lane and the same edge already evaluates its first sample
    always_comb begin
        cs       = start ? HUNT : st;
        cp       = start ? '0 : pos;
        cc       = start ? '0 : cons;
        cons_inc = &cc ? cc : cc + CNT_W'(1);
        st_n     = cs;
        pos_n    = cp;
        prev_n   = prev;
        cons_n   = cc;
        if (stop) begin
            st_n   = HUNT;
            pos_n  = '0;
            cons_n = (cs == GAP && cp >= LOW6) ? cons_inc : cc;
        end else if (active) begin
            case (cs)
                BURST: begin
                    if (sample == prev) begin
                        st_n   = HUNT;
                        cons_n = '0;
                        pos_n  = {5'b0, ~sample};
                    end else if (cp + 6'd1 == HIGH6) begin
                        st_n  = GAP;
                        pos_n = 6'd1;
                    end else begin
                        pos_n  = cp + 6'd1;
                        prev_n = sample;
                    end
                end
                GAP: begin
                    if (!sample) begin
                        pos_n = cp + 6'd1;
                        if (cp + 6'd1 > MAX6) begin
                            st_n   = HUNT;
                            cons_n = '0;
                        end
                    end else if (cp >= LOW6) begin
                        st_n   = BURST;
                        pos_n  = 6'd1;
                        prev_n = 1'b1;
                        cons_n = cons_inc;
                    end else begin
                        st_n   = HUNT;
                        pos_n  = '0;
                        cons_n = '0;
                    end
                end
                default: begin
                    if (!sample) begin
                        pos_n = &cp ? cp : cp + 6'd1;
                    end else if (cp >= LOW6 || start) begin
                        st_n   = BURST;
                        pos_n  = 6'd1;
                        prev_n = 1'b1;
                    end else begin
                        pos_n = '0;
                    end
                end
            endcase
        end
        pass_n = (start ? 1'b0 : pass) | (cons_n >= CNT_W'(PASS_THRESHOLD));
    end

endmodule

// File: rtl/clk_pattern_detector.sv
// clk_pattern_detector: window edge detection and per-lane result reporting for the repair-clock check
module clk_pattern_detector
    import clk_pattern_detector_pkg::*;
#(
    parameter int HIGH_CYCLES    = HIGH_CYCLES_DEF,
    parameter int LOW_CYCLES     = LOW_CYCLES_DEF,
    parameter int LOW_SLACK      = LOW_SLACK_DEF,
    parameter int PASS_THRESHOLD = PASS_THRESHOLD_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic       i_clk1,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_ckp,
    input  logic       i_ckn,
    input  logic       i_track,
    output logic [2:0] o_result,
    output logic       o_done,
    output logic       o_busy
);

    logic       enable_q, done_pend, start, stop;
    logic [2:0] lane_in, pass;

    assign start   = i_enable & ~enable_q;
    assign stop    = ~i_enable & enable_q;
    assign lane_in = {i_track, i_ckn, i_ckp};

    genvar l;
    for (l = 0; l < 3; l++) begin : g_lane
        clk_lane_checker #(
            .HIGH_CYCLES   (HIGH_CYCLES),
            .LOW_CYCLES    (LOW_CYCLES),
            .LOW_SLACK     (LOW_SLACK),
            .PASS_THRESHOLD(PASS_THRESHOLD),
            .CNT_W         (CNT_W)
        ) u_lane (
            .i_clk1 (i_clk1),
            .i_rst_n(i_rst_n),
            .sample (lane_in[l]),
            .start  (start),
            .active (i_enable),
            .stop   (stop),
            .pass   (pass[l])
        );
    end

    // Result is taken one edge after the stop so the lanes' final-iteration credit is included
    always_ff @(posedge i_clk1 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            enable_q  <= 1'b0;
            done_pend <= 1'b0;
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
            o_result  <= '0;
        end else begin
            enable_q  <= i_enable;
            done_pend <= stop;
            o_done    <= done_pend;
            if (done_pend) begin
                o_result <= pass;
                o_busy   <= 1'b0;
            end
            if (start) begin
                o_result <= '0;
                o_busy   <= 1'b1;
            end
        end
    end

endmodule
